// File: rtl/vga_pkg.sv
// Shared screen geometry, coordinate types and engine state encoding for the
// VGA shape-drawing engines.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic        [7:0] coord_x_t;
  typedef logic        [6:0] coord_y_t;
  typedef logic        [2:0] colour_t;
  typedef logic signed [9:0] scoord_t;

  // Octant offsets and the midpoint decision variable of the circle engine.
  typedef logic signed [8:0]  offset_t;
  typedef logic signed [10:0] crit_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLOT,
    STEP,
    DONE
  } circle_state_t;

endpackage

// File: rtl/pixel_clip.sv
// Screen-bounds test for a signed pixel coordinate; passes through the low
// bits for the adapter and flags whether the pixel may be strobed.
module pixel_clip
  import vga_pkg::*;
#(
  parameter int X_LIMIT = SCREEN_W,
  parameter int Y_LIMIT = SCREEN_H
) (
  input  scoord_t  x,
  input  scoord_t  y,
  output coord_x_t px,
  output coord_y_t py,
  output logic     in_bounds
);

  assign px = x[7:0];
  assign py = y[6:0];

  // The sign bit rejects negatives; the upper bound is a signed compare.
  assign in_bounds = !x[9] && !y[9] &&
                     (x < scoord_t'(X_LIMIT)) && (y < scoord_t'(Y_LIMIT));

endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle engine: eight symmetric pixels per iteration, one registered
// plot request per clock, with off-screen pixels suppressed.
module circle_plotter
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  input  coord_x_t centre_x,
  input  coord_y_t centre_y,
  input  logic [7:0] radius,
  input  colour_t  colour,
  output logic     done,
  output coord_x_t vga_x,
  output coord_y_t vga_y,
  output colour_t  vga_colour,
  output logic     vga_plot
);

  circle_state_t state, state_next;

  coord_x_t   cx;
  coord_y_t   cy;
  logic [7:0] r;
  colour_t    col;
  offset_t    ox, oy;
  crit_t      crit;
  logic [2:0] k;

  offset_t oy_inc, ox_new;
  crit_t   crit_new;
  logic    more;

  scoord_t  sx, sy, ecx, ecy, dox, doy;
  coord_x_t clip_x;
  coord_y_t clip_y;
  logic     clip_ok;

  // Midpoint step: the decision update uses the already-advanced oy/ox.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    oy_inc   = oy + 9'sd1;
    ox_new   = ox;
    crit_new = crit + (crit_t'(oy_inc) <<< 1) + 11'sd1;
    if (crit > 11'sd0) begin
      ox_new   = ox - 9'sd1;
      crit_new = crit + ((crit_t'(oy_inc) - crit_t'(ox_new)) <<< 1) + 11'sd1;
    end
    more = (oy_inc <= ox_new);
  end

  always_comb begin
    ecx = scoord_t'({2'b00, cx});
    ecy = scoord_t'({3'b000, cy});
    dox = scoord_t'(ox);
    doy = scoord_t'(oy);
    sx  = ecx + dox;
    sy  = ecy + doy;
    case (k)
      3'd0: begin sx = ecx + dox; sy = ecy + doy; end
      3'd1: begin sx = ecx + doy; sy = ecy + dox; end
      3'd2: begin sx = ecx - dox; sy = ecy + doy; end
      3'd3: begin sx = ecx - doy; sy = ecy + dox; end
      3'd4: begin sx = ecx - dox; sy = ecy - doy; end
      3'd5: begin sx = ecx - doy; sy = ecy - dox; end
      3'd6: begin sx = ecx + dox; sy = ecy - doy; end
      3'd7: begin sx = ecx + doy; sy = ecy - dox; end
      default: ;
    endcase
  end

  pixel_clip #(
    .X_LIMIT(SCREEN_W),
    .Y_LIMIT(SCREEN_H)
  ) u_clip (
    .x        (sx),
    .y        (sy),
    .px       (clip_x),
    .py       (clip_y),
    .in_bounds(clip_ok)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    state_next = PLOT;
      PLOT:    if (k == 3'd7) state_next = STEP;
      STEP:    state_next = more ? PLOT : DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx         <= '0;
      cy         <= '0;
      r          <= '0;
      col        <= '0;
      ox         <= '0;
      oy         <= '0;
      crit       <= '0;
      k          <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cx  <= centre_x;
            cy  <= centre_y;
            r   <= radius;
            col <= colour;
          end
        end
        INIT: begin
          ox   <= offset_t'({1'b0, r});
          oy   <= '0;
          crit <= 11'sd1 - crit_t'({3'b000, r});
          k    <= '0;
        end
        PLOT: begin
          k          <= k + 3'd1;
          vga_x      <= clip_x;
          vga_y      <= clip_y;
          vga_colour <= col;
          vga_plot   <= clip_ok;
        end
        STEP: begin
          oy   <= oy_inc;
          ox   <= ox_new;
          crit <= crit_new;
          k    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_plotter.sv
// Directed and randomized checks of circle_plotter against an integer midpoint
// reference model of the expected strobe sequence and draw length.
module tb_circle_plotter;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [2:0] colour = '0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int errors = 0;
  int checks = 0;

  pix_t got_q[$];
  pix_t exp_q[$];

  circle_plotter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .centre_x  (centre_x),
    .centre_y  (centre_y),
    .radius    (radius),
    .colour    (colour),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the midpoint recurrence on plain integers, listing the visible pixels.
  task automatic model_draw(input int cx, input int cy, input int r, input int col,
                            output int iters);
    int ox, oy, crit;
    int xs[8];
    int ys[8];
    exp_q.delete();
    ox = r; oy = 0; crit = 1 - r; iters = 0;
    do begin
      xs = '{cx + ox, cx + oy, cx - ox, cx - oy, cx - ox, cx - oy, cx + ox, cx + oy};
      ys = '{cy + oy, cy + ox, cy + oy, cy + ox, cy - oy, cy - ox, cy - oy, cy - ox};
      for (int i = 0; i < 8; i++)
        if (xs[i] >= 0 && xs[i] < 160 && ys[i] >= 0 && ys[i] < 120)
          exp_q.push_back('{x: 8'(xs[i]), y: 7'(ys[i]), c: 3'(col)});
      iters++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  // Starts a draw at a negedge and collects strobes until done; inputs are
  // scrambled once latched to show they are ignored.
  task automatic run_draw(input int cx, input int cy, input int r, input int col,
                          output int cycles);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius   = 8'(r);
    colour   = 3'(col);
    start    = 1'b1;
    got_q.delete();
    cycles = 0;
    while (done !== 1'b1 && cycles < 4000) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        centre_x = 8'($urandom);
        centre_y = 7'($urandom);
        radius   = 8'($urandom);
        colour   = 3'($urandom);
      end
      if (vga_plot === 1'b1) got_q.push_back('{x: vga_x, y: vga_y, c: vga_colour});
    end
    check("draw_completes", done, 1'b1);
  endtask

  task automatic compare_draw(input string tag, input int iters, input int cycles);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    check({tag, "_cycles"}, cycles, 2 + 9 * iters);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic end_draw(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("done_hold", done, 1'b1);
      check("no_plot_in_done", vga_plot, 1'b0);
    end
    start = 1'b0;
    #1;
    check("done_until_edge", done, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("done_drop", done, 1'b0);
  endtask

  initial begin
    int iters, iters_ref, cycles, cnt, dx, dy, d;
    logic [2:0] c;
    int tbl_x[16];
    int tbl_y[16];

    // Reset values
    #12;
    check("rst_done", done, 1'b0);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_x", vga_x, 8'd0);
    check("rst_y", vga_y, 7'd0);
    check("rst_colour", vga_colour, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_plot", vga_plot, 1'b0);

    // Radius 0: eight coincident pixels
    c = 3'($urandom);
    model_draw(80, 60, 0, c, iters);
    run_draw(80, 60, 0, c, cycles);
    compare_draw("r0", iters, cycles);
    check("r0_strobes", got_q.size(), 8);
    end_draw(3);

    // Radius 1 against the hand-derived pixel order
    c = 3'($urandom);
    tbl_x = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
    tbl_y = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{x: 8'(tbl_x[i]), y: 7'(tbl_y[i]), c: c});
    run_draw(80, 60, 1, c, cycles);
    compare_draw("r1", 2, cycles);
    end_draw(1);

    // Clipping at the top-left corner
    model_draw(80, 60, 10, 5, iters_ref);
    model_draw(0, 0, 10, 5, iters);
    run_draw(0, 0, 10, 5, cycles);
    compare_draw("clip", iters, cycles);
    check("clip_cycles_unclipped", cycles, 2 + 9 * iters_ref);
    cnt = 0;
    foreach (got_q[i]) begin
      check("clip_x_range", got_q[i].x < 8'd160, 1'b1);
      check("clip_y_range", got_q[i].y < 7'd120, 1'b1);
      if (got_q[i].x == 8'd246 && got_q[i].y == 7'd0) cnt++;
    end
    check("clip_neg10_suppressed", cnt, 0);
    if (got_q.size() > 0) check("clip_first_10_0", {got_q[0].x, got_q[0].y}, {8'd10, 7'd0});
    else check("clip_first_10_0", got_q.size(), 1);
    end_draw(1);

    // Radius 30 ring accuracy
    model_draw(80, 60, 30, 3'b010, iters);
    run_draw(80, 60, 30, 3'b010, cycles);
    compare_draw("r30", iters, cycles);
    check("r30_strobes", got_q.size(), 8 * iters);
    foreach (got_q[i]) begin
      dx = int'(got_q[i].x) - 80;
      dy = int'(got_q[i].y) - 60;
      d  = dx * dx + dy * dy - 900;
      check("r30_ring", (d <= 30 && d >= -30), 1'b1);
    end
    end_draw(1);

    // Back-to-back draws with a single idle cycle between them
    model_draw(80, 60, 5, 3'b001, iters);
    run_draw(80, 60, 5, 3'b001, cycles);
    compare_draw("b2b_first", iters, cycles);
    end_draw(0);
    model_draw(80, 60, 7, 3'b100, iters);
    run_draw(80, 60, 7, 3'b100, cycles);
    compare_draw("b2b_second", iters, cycles);
    end_draw(1);

    // Randomized draws anywhere on the coordinate range
    for (int n = 0; n < 5; n++) begin
      int rx, ry, rr, rc;
      rx = $urandom_range(0, 255);
      ry = $urandom_range(0, 127);
      rr = $urandom_range(0, 255);
      rc = $urandom_range(0, 7);
      model_draw(rx, ry, rr, rc, iters);
      run_draw(rx, ry, rr, rc, cycles);
      compare_draw($sformatf("rand%0d", n), iters, cycles);
      end_draw(n % 2);
    end

    // Reset in the middle of a draw
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius   = 8'd40;
    colour   = 3'b111;
    start    = 1'b1;
    cnt = 0;
    cycles = 0;
    while (cnt < 20 && cycles < 500) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (vga_plot === 1'b1) cnt++;
    end
    check("mid_reach_20", cnt, 20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_plot", vga_plot, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_x", vga_x, 8'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (vga_plot !== 1'b0 || done !== 1'b0) cnt++;
    end
    check("mid_idle_quiet", cnt, 0);
    model_draw(80, 60, 3, 6, iters);
    run_draw(80, 60, 3, 6, cycles);
    compare_draw("post_rst", iters, cycles);
    end_draw(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
